alu_writeback_stage: RTL
========================

// Module: alu_writeback_stage
// PURPOSE
//  Pipeline stage directly downstream of the ALU. Buffers ALU results (F, stat, Cout-derived flags)
//  in a 2-entry FIFO with valid/ready handshake, commits results to the register-file write port,
//  holds the architectural NZCV flag register, and evaluates a 4-bit condition code for conditional
//  branches. It decouples ALU issue from register-file/branch-unit back-pressure.
// PARAMETERS
//  DATA_W   64  result width; equals ALU F width
//  ADDR_W   5   register-file address width (32 regs; reg 31 = zero register)
//  DEPTH    2   FIFO entries; only 2 is supported (count register is 2 bits)
// PORTS
//  clock       in   1       rising-edge clock
//  reset_n     in   1       asynchronous active-low reset
//  in_valid    in   1       ALU result valid this cycle
//  in_ready    out  1       stage can accept; = (count != DEPTH)
//  in_F        in   DATA_W  ALU result F
//  in_stat     in   4       ALU status {V,C,N,Z}
//  in_rd       in   ADDR_W  destination register
//  in_wen      in   1       result is to be written to register file
//  in_setf     in   1       result updates the flag register at commit
//  in_cond_en  in   1       entry is a conditional branch; evaluate in_cond
//  in_cond     in   4       condition code (table below)
//  wb_valid    out  1       head entry present (count != 0)
//  wb_ready    in   1       consumer accepts head this cycle
//  wb_data     out  DATA_W  head F
//  wb_addr     out  ADDR_W  head rd
//  wb_wen      out  1       head wen & wb_valid & (rd != 31)
//  wb_taken    out  1       head cond_en & wb_valid & cond(flags)
//  flags       out  4       committed flag register {V,C,N,Z}
// BEHAVIOUR
//  - Reset (async, reset_n=0): count=0, rd/wr pointers=0, flags=4'b0000, entry storage cleared;
//    hence in_ready=1, wb_valid=0, wb_wen=0, wb_taken=0, wb_data=0, wb_addr=0.
//  - Push when in_valid & in_ready; pop when wb_valid & wb_ready. Both on same rising edge.
//  - Latency: entry pushed at edge N appears at wb_* after edge N (visible in cycle N+1); no
//    same-cycle pass-through from in_* to wb_*.
//  - Full (count=2): in_ready=0 even if wb_ready=1 that cycle; in_valid ignored.
//  - Empty (count=0): pop ignored; wb_data/wb_addr show stale storage but wb_wen=wb_taken=0.
//  - Simultaneous push+pop with count=1: count stays 1, pointers both advance (wrap mod 2).
//  - Commit: on pop of an entry with setf=1, flags <= entry stat at that edge.
//  - wb_taken evaluates entry cond against committed flags (before that entry's own update).
//  - Conditions: 0 EQ Z | 1 NE !Z | 2 CS C | 3 CC !C | 4 MI N | 5 PL !N | 6 VS V | 7 VC !V |
//    8 HI C&!Z | 9 LS !C|Z | 10 GE N==V | 11 LT N!=V | 12 GT !Z&(N==V) | 13 LE Z|(N!=V) |
//    14 AL 1 | 15 NV treated as AL (1).
//  - Writes to rd=31 are accepted and popped normally but wb_wen is forced 0.
//  - Reset mid-operation: all buffered entries discarded, flags cleared; no partial commit.
//  - in_* must be held stable while in_valid=1 and in_ready=0.
// CONFIGURATION
//  ALU_WB_FWD_EN defined: adds outputs fwd_valid(1), fwd_addr(ADDR_W), fwd_data(DATA_W) exposing
//    youngest buffered entry with wen=1 and rd!=31 (tail over head), for operand bypass upstream;
//    fwd_valid=0 when none; reset value 0 on all three.
//  ALU_WB_FWD_EN undefined: those ports and their logic do not exist; all other behaviour identical.
// TESTING
//  1 Reset: reset_n=0 mid-stream with count=2 -> in_ready=1, wb_valid=0, flags=0 immediately.
//  2 Push F=64'h5,rd=3,wen=1, wb_ready=1 -> next cycle wb_wen=1,wb_addr=3,wb_data=5; popped.
//  3 wb_ready=0, push 3 entries back-to-back -> in_ready drops after 2nd; 3rd held until pop.
//  4 Push setf=1 stat=4'b0001 then cond_en=1 cond=0(EQ) -> 2nd head wb_taken=1; cond=1(NE) -> 0.
//  5 Push setf=1 stat={V=1,C=0,N=0,Z=0}, then cond=11(LT) -> wb_taken=1; cond=10(GE) -> 0.
//  6 Push rd=31 wen=1 -> wb_valid=1, wb_wen=0; with ALU_WB_FWD_EN, fwd_valid=0 for that entry.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
//   Pipeline stage after the ALU. Results go into a 2-entry FIFO with a valid/ready
//   handshake on both sides. The head entry drives the register-file write port and the
//   branch-condition output. The stage also holds the committed NZCV flag register.
//
//   Optional feature: when ALU_WB_FWD_EN is defined, the module adds fwd_valid, fwd_addr
//   and fwd_data. These expose the youngest buffered entry that really writes a register,
//   so the upstream logic can bypass operands.
//
//   Ports
//     clock, reset_n          rising-edge clock, async active-low reset
//     in_valid / in_ready     producer handshake (in_ready = not full)
//     in_F, in_stat, in_rd    ALU result, status {V,C,N,Z}, destination register
//     in_wen, in_setf         register write enable, flag update at commit
//     in_cond_en, in_cond     conditional-branch marker and 4-bit condition code
//     wb_valid / wb_ready     consumer handshake (wb_valid = not empty)
//     wb_data, wb_addr        head result and destination
//     wb_wen                  head write enable, forced 0 for the zero register
//     wb_taken                head condition evaluated against committed flags
//     flags                   committed flag register {V,C,N,Z}
//     fwd_valid/addr/data     youngest forwardable entry (ALU_WB_FWD_EN only)
module alu_writeback_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_F,
  input  logic [3:0]        in_stat,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wen,
  input  logic              in_setf,
  input  logic              in_cond_en,
  input  logic [3:0]        in_cond,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_wen,
  output logic              wb_taken,
`ifdef ALU_WB_FWD_EN
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [3:0]        flags
);

  // The highest register number is the hard-wired zero register.
  localparam logic [ADDR_W-1:0] ZeroReg = '1;

  logic [DATA_W-1:0] data_q    [2];
  logic [3:0]        stat_q    [2];
  logic [ADDR_W-1:0] rd_q      [2];
  logic              wen_q     [2];
  logic              setf_q    [2];
  logic              cond_en_q [2];
  logic [3:0]        cond_q    [2];

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, rd_ptr_q;
  logic [3:0] flags_q, flags_d;
  logic       push, pop;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic v, cf, n, z;
    v  = f[3];
    cf = f[2];
    n  = f[1];
    z  = f[0];
    case (c)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = !z;
      4'd2:    cond_eval = cf;
      4'd3:    cond_eval = !cf;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = !n;
      4'd6:    cond_eval = v;
      4'd7:    cond_eval = !v;
      4'd8:    cond_eval = cf && !z;
      4'd9:    cond_eval = !cf || z;
      4'd10:   cond_eval = (n == v);
      4'd11:   cond_eval = (n != v);
      4'd12:   cond_eval = !z && (n == v);
      4'd13:   cond_eval = z || (n != v);
      default: cond_eval = 1'b1;  // AL, and NV behaves as AL
    endcase
  endfunction

  assign in_ready = (count_q != 2'(DEPTH));
  assign wb_valid = (count_q != 2'd0);
  assign push     = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (pop && setf_q[rd_ptr_q]) flags_d = stat_q[rd_ptr_q];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      flags_q  <= 4'b0000;
      for (int i = 0; i < 2; i++) begin
        data_q[i]    <= '0;
        stat_q[i]    <= '0;
        rd_q[i]      <= '0;
        wen_q[i]     <= 1'b0;
        setf_q[i]    <= 1'b0;
        cond_en_q[i] <= 1'b0;
        cond_q[i]    <= '0;
      end
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
      if (push) begin
        data_q[wr_ptr_q]    <= in_F;
        stat_q[wr_ptr_q]    <= in_stat;
        rd_q[wr_ptr_q]      <= in_rd;
        wen_q[wr_ptr_q]     <= in_wen;
        setf_q[wr_ptr_q]    <= in_setf;
        cond_en_q[wr_ptr_q] <= in_cond_en;
        cond_q[wr_ptr_q]    <= in_cond;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage is visible even when empty. The qualifiers keep that stale data harmless.
  assign wb_data  = data_q[rd_ptr_q];
  assign wb_addr  = rd_q[rd_ptr_q];
  assign wb_wen   = wb_valid && wen_q[rd_ptr_q] && (rd_q[rd_ptr_q] != ZeroReg);
  assign wb_taken = wb_valid && cond_en_q[rd_ptr_q] && cond_eval(cond_q[rd_ptr_q], flags_q);
  assign flags    = flags_q;

`ifdef ALU_WB_FWD_EN
  // The youngest entry sits just behind the write pointer. The head is a distinct,
  // older entry only when the FIFO holds two entries.
  logic tail_idx, tail_ok, head_ok;

  assign tail_idx = ~wr_ptr_q;
  assign tail_ok  = (count_q != 2'd0) && wen_q[tail_idx] && (rd_q[tail_idx] != ZeroReg);
  assign head_ok  = (count_q == 2'd2) && wen_q[rd_ptr_q] && (rd_q[rd_ptr_q] != ZeroReg);

  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    if (tail_ok) begin
      fwd_valid = 1'b1;
      fwd_addr  = rd_q[tail_idx];
      fwd_data  = data_q[tail_idx];
    end else if (head_ok) begin
      fwd_valid = 1'b1;
      fwd_addr  = rd_q[rd_ptr_q];
      fwd_data  = data_q[rd_ptr_q];
    end
  end
`endif

endmodule
